// File: rtl/axi_lite_master_arb.sv
// Round-robin AXI4-lite master: arbitrates NUM_M requesters onto one AXI4-lite port,
// one outstanding transaction at a time, with a one-cycle completion pulse per port.
module axi_lite_master_arb #(
  parameter int         NUM_M      = 2,
  parameter int         ADDR_WIDTH = 32,
  parameter int         DATA_WIDTH = 32,
  parameter int         STRB_WIDTH = DATA_WIDTH/8,
  parameter logic [2:0] PROT       = 3'b000
) (
  input  logic                             ACLK,
  input  logic                             ARESET,
  input  logic [NUM_M-1:0]                 M_access,
  input  logic [NUM_M-1:0]                 M_rd0_wr1,
  input  logic [NUM_M*ADDR_WIDTH-1:0]      M_addr,
  input  logic [NUM_M*DATA_WIDTH-1:0]      M_write_data,
  input  logic [NUM_M*STRB_WIDTH-1:0]      M_write_strobe,
  output logic [NUM_M-1:0]                 ready_M,
  output logic [NUM_M-1:0]                 resp_valid_M,
  output logic [NUM_M-1:0]                 read_data_valid_M,
  output logic [DATA_WIDTH-1:0]            read_data_M,
  output logic [1:0]                       resp_M,
  output logic                             AWVALID,
  input  logic                             AWREADY,
  output logic [ADDR_WIDTH-1:0]            AWADDR,
  output logic [2:0]                       AWPROT,
  output logic                             WVALID,
  input  logic                             WREADY,
  output logic [DATA_WIDTH-1:0]            WDATA,
  output logic [STRB_WIDTH-1:0]            WSTRB,
  input  logic                             BVALID,
  output logic                             BREADY,
  input  logic [1:0]                       BRESP,
  output logic                             ARVALID,
  input  logic                             ARREADY,
  output logic [ADDR_WIDTH-1:0]            ARADDR,
  output logic [2:0]                       ARPROT,
  input  logic                             RVALID,
  output logic                             RREADY,
  input  logic [DATA_WIDTH-1:0]            RDATA,
  input  logic [1:0]                       RRESP
);

  localparam int GW = (NUM_M > 1) ? $clog2(NUM_M) : 1;
  localparam int IW = GW + 1;

  typedef enum logic [2:0] {S_IDLE, S_WADDR, S_WRESP, S_RADDR, S_RDATA, S_DONE} state_t;

  state_t                                r_state, w_next;
  logic [GW-1:0]                         r_last;
  logic [ADDR_WIDTH-1:0]                 r_addr;
  logic [DATA_WIDTH-1:0]                 r_wdata;
  logic [STRB_WIDTH-1:0]                 r_strb;
  logic                                  r_wr;
  logic                                  r_aw_done, r_w_done;
  logic [1:0]                            r_resp;
  logic [DATA_WIDTH-1:0]                 r_rdata;

  logic [NUM_M-1:0][ADDR_WIDTH-1:0]      w_addr_arr;
  logic [NUM_M-1:0][DATA_WIDTH-1:0]      w_data_arr;
  logic [NUM_M-1:0][STRB_WIDTH-1:0]      w_strb_arr;
  logic [IW-1:0]                         w_idx;
  logic [GW-1:0]                         w_grant;
  logic                                  w_found;
  logic                                  w_accept;

  assign w_addr_arr = M_addr;
  assign w_data_arr = M_write_data;
  assign w_strb_arr = M_write_strobe;
  assign AWPROT     = PROT;
  assign ARPROT     = PROT;

  // Cyclic search starting one past the previous winner; first requester found wins.
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    w_idx   = '0;
    for (int k = 1; k <= NUM_M; k++) begin
      w_idx = {1'b0, r_last} + IW'(k);
      if (w_idx >= IW'(NUM_M)) w_idx = w_idx - IW'(NUM_M);
      if (!w_found && M_access[w_idx[GW-1:0]]) begin
        w_found = 1'b1;
        w_grant = w_idx[GW-1:0];
      end
    end
  end

  assign w_accept = (r_state == S_IDLE) && w_found && !ARESET;

  always_ff @(posedge ACLK) begin
    if (ARESET) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next            = r_state;
    ready_M           = '0;
    resp_valid_M      = '0;
    read_data_valid_M = '0;
    read_data_M       = '0;
    resp_M            = '0;
    AWVALID           = 1'b0;
    AWADDR            = '0;
    WVALID            = 1'b0;
    WDATA             = '0;
    WSTRB             = '0;
    BREADY            = 1'b0;
    ARVALID           = 1'b0;
    ARADDR            = '0;
    RREADY            = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          ready_M[w_grant] = 1'b1;
          w_next = M_rd0_wr1[w_grant] ? S_WADDR : S_RADDR;
        end
      end
      S_WADDR: begin
        AWVALID = !r_aw_done;
        WVALID  = !r_w_done;
        AWADDR  = r_addr;
        WDATA   = r_wdata;
        WSTRB   = r_strb;
        if ((r_aw_done || AWREADY) && (r_w_done || WREADY)) w_next = S_WRESP;
      end
      S_WRESP: begin
        BREADY = 1'b1;
        if (BVALID) w_next = S_DONE;
      end
      S_RADDR: begin
        ARVALID = 1'b1;
        ARADDR  = r_addr;
        if (ARREADY) w_next = S_RDATA;
      end
      S_RDATA: begin
        RREADY = 1'b1;
        if (RVALID) w_next = S_DONE;
      end
      S_DONE: begin
        resp_valid_M[r_last] = 1'b1;
        resp_M               = r_resp;
        if (!r_wr) begin
          read_data_valid_M[r_last] = 1'b1;
          read_data_M               = r_rdata;
        end
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_last    <= GW'(NUM_M - 1);
      r_addr    <= '0;
      r_wdata   <= '0;
      r_strb    <= '0;
      r_wr      <= 1'b0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_resp    <= '0;
      r_rdata   <= '0;
    end else begin
      if (w_accept) begin
        r_last    <= w_grant;
        r_addr    <= w_addr_arr[w_grant];
        r_wdata   <= w_data_arr[w_grant];
        r_strb    <= w_strb_arr[w_grant];
        r_wr      <= M_rd0_wr1[w_grant];
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
      end
      if (AWVALID && AWREADY) r_aw_done <= 1'b1;
      if (WVALID && WREADY)   r_w_done  <= 1'b1;
      if (BREADY && BVALID)   r_resp    <= BRESP;
      if (RREADY && RVALID) begin
        r_resp  <= RRESP;
        r_rdata <= RDATA;
      end
    end
  end

endmodule
